// File: rtl/i2s_rx.sv
// Philips I2S slave receiver (i2s_rx) and its companion transmitter (i2s_tx).
// Both run on the I2S bit clock; the receiver samples on rising edges and the transmitter drives on falling edges.

module i2s_rx #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             ws_in,
    input  logic             sdata_in,
    output logic [WIDTH-1:0] left_chan,
    output logic [WIDTH-1:0] right_chan,
    output logic             pktI2SRxChanged_o
);

    logic             ws_q;
    logic [WIDTH-1:0] sr_q,        sr_d;
    logic [WIDTH-1:0] left_q,      left_d;
    logic [WIDTH-1:0] right_q,     right_d;
    logic [WIDTH-1:0] prev_left_q, prev_left_d;
    logic             chg_q,       chg_d;

    logic [WIDTH-1:0] word;
    logic             boundary;

    // The bit sampled on the boundary edge is the LSB of the word that is ending.
    assign word     = {sr_q[WIDTH-2:0], sdata_in};
    assign boundary = (ws_in != ws_q);

    // Word capture and frame-change detection.
    always_comb begin
        sr_d        = word;
        left_d      = left_q;
        right_d     = right_q;
        prev_left_d = prev_left_q;
        chg_d       = 1'b0;
        if (boundary) begin
            sr_d = '0;
            if (!ws_q) begin
                left_d = word;
            end else begin
                // right_q still holds the right word of the previous completed frame
                right_d     = word;
                prev_left_d = left_q;
                chg_d       = (left_q != prev_left_q) || (word != right_q);
            end
        end
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            ws_q        <= 1'b0;
            sr_q        <= '0;
            left_q      <= '0;
            right_q     <= '0;
            prev_left_q <= '0;
            chg_q       <= 1'b0;
        end else begin
            ws_q        <= ws_in;
            sr_q        <= sr_d;
            left_q      <= left_d;
            right_q     <= right_d;
            prev_left_q <= prev_left_d;
            chg_q       <= chg_d;
        end
    end

    assign left_chan         = left_q;
    assign right_chan        = right_q;
    assign pktI2SRxChanged_o = chg_q;

endmodule

module i2s_tx #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             sclk,
    input  logic             rst,
    output logic             ws_out,
    output logic             sdata_out,
    input  logic [WIDTH-1:0] left_chan,
    input  logic [WIDTH-1:0] right_chan
);

    localparam int unsigned FRAME_W = 2 * WIDTH;
    localparam int unsigned CNT_W   = $clog2(FRAME_W);
    localparam int unsigned CNT_MAX = FRAME_W - 1;

    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               ws_q,    ws_d;

    // Both words are latched together at frame start; the frame then shifts out MSB first.
    always_comb begin
        cnt_d   = (cnt_q == CNT_W'(CNT_MAX)) ? '0 : cnt_q + CNT_W'(1);
        frame_d = frame_q << 1;
        if (cnt_d == '0) begin
            frame_d = {left_chan, right_chan};
        end
        ws_d = (cnt_d >= CNT_W'(WIDTH - 1)) && (cnt_d != CNT_W'(CNT_MAX));
    end

    // Counter resets to its last value so the first falling edge starts a frame.
    always_ff @(negedge sclk or posedge rst) begin
        if (rst) begin
            cnt_q   <= CNT_W'(CNT_MAX);
            frame_q <= '0;
            ws_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            ws_q    <= ws_d;
        end
    end

    assign ws_out    = ws_q;
    assign sdata_out = frame_q[FRAME_W-1];

endmodule

// File: tb/tb_i2s_rx.sv
// Directed testbench for i2s_rx: hand-driven I2S frames, then tx->rx loopback.

module tb_i2s_rx;

    localparam int unsigned W = 16;

    logic         sclk = 1'b0;
    logic         rst  = 1'b1;
    logic         ws_in = 1'b0;
    logic         sdata_in = 1'b0;
    logic         loop_sel = 1'b0;
    logic         rx_ws, rx_sd;
    logic [W-1:0] left, right;
    logic         pulse;
    logic         tx_ws, tx_sd;
    logic [W-1:0] tx_l = 16'hCAFE;
    logic [W-1:0] tx_r = 16'h0F0F;

    int n_vec = 0;
    int n_err = 0;
    int pulse_cnt = 0;
    int at;

    always #5 sclk = ~sclk;

    assign rx_ws = loop_sel ? tx_ws : ws_in;
    assign rx_sd = loop_sel ? tx_sd : sdata_in;

    i2s_rx #(.WIDTH(W)) dut (
        .sclk              (sclk),
        .rst               (rst),
        .ws_in             (rx_ws),
        .sdata_in          (rx_sd),
        .left_chan         (left),
        .right_chan        (right),
        .pktI2SRxChanged_o (pulse)
    );

    i2s_tx #(.WIDTH(W)) u_tx (
        .sclk       (sclk),
        .rst        (rst),
        .ws_out     (tx_ws),
        .sdata_out  (tx_sd),
        .left_chan  (tx_l),
        .right_chan (tx_r)
    );

    always @(negedge sclk) begin
        if (!rst && pulse) pulse_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic settle();
        @(posedge sclk);
        #1;
    endtask

    task automatic send_bit(input logic ws, input logic d);
        @(negedge sclk);
        ws_in    = ws;
        sdata_in = d;
    endtask

    // WS flips on the LSB of each word, one bit ahead of the next MSB.
    task automatic send_word(input logic [W-1:0] v, input int n, input logic ch);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit((i == 0) ? ~ch : ch, v[i]);
        end
    endtask

    task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r);
        send_word(l, W, 1'b0);
        send_word(r, W, 1'b1);
    endtask

    task automatic wait_pulse(input int start, output int edge_no);
        edge_no = -1;
        for (int e = start; e <= 4 * W; e++) begin
            settle();
            if (pulse) begin
                edge_no = e;
                break;
            end
        end
    endtask

    initial begin
        repeat (10) @(posedge sclk);
        #1;
        chk("rst_left",  32'(left),  32'h0);
        chk("rst_right", 32'(right), 32'h0);
        chk("rst_pulse", 32'(pulse), 32'h0);
        chk("rst_ws_out", 32'(tx_ws), 32'h0);
        chk("rst_sdata_out", 32'(tx_sd), 32'h0);
        rst = 1'b0;

        send_frame(16'hDEAD, 16'hBEEF);
        settle();
        chk("f1_pulse", 32'(pulse), 32'h1);
        chk("f1_left",  32'(left),  32'hDEAD);
        chk("f1_right", 32'(right), 32'hBEEF);
        repeat (10) send_bit(1'b0, 1'b1);
        settle();
        chk("f1_idle_pulses", 32'(pulse_cnt), 32'd1);

        send_frame(16'h1234, 16'hABCD);
        settle();
        chk("f2_pulse", 32'(pulse), 32'h1);
        chk("f2_left",  32'(left),  32'h1234);
        chk("f2_right", 32'(right), 32'hABCD);

        send_frame(16'h1234, 16'hABCD);
        settle();
        chk("f3_no_pulse", 32'(pulse), 32'h0);
        chk("f3_left",  32'(left),  32'h1234);
        chk("f3_right", 32'(right), 32'hABCD);

        send_word(16'h00AB, 8, 1'b0);
        settle();
        chk("short_left", 32'(left), 32'h00AB);
        send_word(16'hABCD, W, 1'b1);
        settle();
        chk("short_pulse", 32'(pulse), 32'h1);
        chk("short_right", 32'(right), 32'hABCD);

        repeat (40) send_bit(1'b0, 1'($urandom));
        settle();
        chk("hold_left",   32'(left),  32'h00AB);
        chk("hold_right",  32'(right), 32'hABCD);
        chk("hold_pulses", 32'(pulse_cnt), 32'd3);

        // Loopback from a common reset.
        @(negedge sclk);
        loop_sel = 1'b1;
        rst      = 1'b1;
        repeat (3) settle();
        chk("lb_rst_left",  32'(left),  32'h0);
        chk("lb_rst_right", 32'(right), 32'h0);
        rst = 1'b0;
        repeat (W - 1) settle();
        chk("lb_pre_left", 32'(left), 32'h0);
        wait_pulse(W, at);
        chk("lb_latency", 32'(at), 32'(2 * W));
        chk("lb_left",  32'(left),  32'hCAFE);
        chk("lb_right", 32'(right), 32'h0F0F);
        repeat (2 * W) settle();
        chk("lb_repeat_pulses", 32'(pulse_cnt), 32'd4);

        // Reset in the middle of a frame.
        repeat (10) settle();
        rst = 1'b1;
        settle();
        chk("mid_rst_left",  32'(left),  32'h0);
        chk("mid_rst_right", 32'(right), 32'h0);
        chk("mid_rst_ws",    32'(tx_ws), 32'h0);
        repeat (2) settle();
        rst = 1'b0;
        repeat (W - 1) settle();
        chk("mid_partial_left",  32'(left),  32'h0);
        chk("mid_partial_right", 32'(right), 32'h0);
        wait_pulse(W, at);
        chk("mid_latency", 32'(at), 32'(2 * W));
        chk("mid_left",  32'(left),  32'hCAFE);
        chk("mid_right", 32'(right), 32'h0F0F);

        // A mid-frame input change only appears in the following frame.
        repeat (5) settle();
        tx_l = 16'h1357;
        wait_pulse(1, at);
        chk("chg_latency", 32'(at), 32'(4 * W - 5));
        chk("chg_left",  32'(left),  32'h1357);
        chk("chg_right", 32'(right), 32'h0F0F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
